// File: rtl/dpi_stream_sequencer.sv
// Flow-tagged byte stream to regex-wrapper sequencer: tag lookup, load_state/char_in/eop
// generation with fixed load-to-char and char-to-eop spacing.
module dpi_stream_sequencer #(
    parameter int unsigned LOAD_GAP = 2,
    parameter int unsigned EOP_GAP  = 2,
    parameter int unsigned KEY_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic [KEY_W-1:0] in_flow_key,
    input  logic             in_enable,
    output logic             load_state,
    output logic             new_stream_id,
    output logic [5:0]       stream_id,
    output logic             enable,
    output logic [7:0]       char_in,
    output logic             char_in_vld,
    output logic             eop,
    output logic [15:0]      pkt_count,
    output logic             proto_err
);

    typedef enum logic [2:0] {
        StIdle, StLookup, StLoad, StGap, StStream, StDrain, StEop
    } state_e;

    // Counter terminal values; every output is registered, so each wait state is one short.
    localparam logic [7:0] LoadCntMax = 8'(LOAD_GAP - 2);
    localparam logic [7:0] EopCntMax  = 8'((EOP_GAP > 1) ? (EOP_GAP - 2) : 32'd0);

    state_e           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             en_cap_q, en_cap_d;
    logic             first_q, first_d;
    logic [5:0]       alloc_q, alloc_d;
    logic [63:0]      valid_q, valid_d;
    logic [KEY_W-1:0] tag_q [64];
    logic             tag_we;
    logic [5:0]       sid_q, sid_d;
    logic             new_q, new_d;
    logic             enable_q, enable_d;
    logic             load_q, load_d;
    logic [7:0]       char_q, char_d;
    logic             vld_q, vld_d;
    logic             eop_q, eop_d;
    logic [15:0]      pkt_q, pkt_d;
    logic             err_q, err_d;
    logic             hit;
    logic [5:0]       hit_idx;

    // Descending scan so the lowest matching index ends up selected.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 6'd0;
        for (int i = 63; i >= 0; i--) begin
            if (valid_q[i] && (tag_q[i] == key_q)) begin
                hit     = 1'b1;
                hit_idx = 6'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        key_d    = key_q;
        en_cap_d = en_cap_q;
        first_d  = first_q;
        alloc_d  = alloc_q;
        valid_d  = valid_q;
        tag_we   = 1'b0;
        sid_d    = sid_q;
        new_d    = new_q;
        enable_d = enable_q;
        load_d   = 1'b0;
        char_d   = char_q;
        vld_d    = 1'b0;
        eop_d    = 1'b0;
        pkt_d    = pkt_q;
        err_d    = err_q;
        in_ready = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (in_sop) begin
                        // Sop beat stays at the head; it is consumed as the first char.
                        key_d    = in_flow_key;
                        en_cap_d = in_enable;
                        state_d  = StLookup;
                    end else begin
                        in_ready = 1'b1;
                        err_d    = 1'b1;
                    end
                end
            end
            StLookup: begin
                enable_d = en_cap_q;
                if (hit) begin
                    sid_d = hit_idx;
                    new_d = 1'b0;
                end else begin
                    sid_d            = alloc_q;
                    new_d            = 1'b1;
                    tag_we           = 1'b1;
                    valid_d[alloc_q] = 1'b1;
                    alloc_d          = alloc_q + 6'd1;
                end
                state_d = StLoad;
            end
            StLoad: begin
                load_d  = 1'b1;
                cnt_d   = 8'd0;
                state_d = StGap;
            end
            StGap: begin
                if (cnt_q == LoadCntMax) begin
                    first_d = 1'b1;
                    state_d = StStream;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StStream: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    char_d  = in_data;
                    vld_d   = 1'b1;
                    first_d = 1'b0;
                    if (in_sop && !first_q) begin
                        err_d = 1'b1;
                    end
                    if (in_eop) begin
                        cnt_d   = 8'd0;
                        state_d = (EOP_GAP > 1) ? StDrain : StEop;
                    end
                end
            end
            StDrain: begin
                if (cnt_q == EopCntMax) begin
                    state_d = StEop;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StEop: begin
                eop_d   = 1'b1;
                pkt_d   = pkt_q + 16'd1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 8'd0;
            key_q    <= '0;
            en_cap_q <= 1'b0;
            first_q  <= 1'b0;
            alloc_q  <= 6'd0;
            valid_q  <= 64'd0;
            sid_q    <= 6'd0;
            new_q    <= 1'b0;
            enable_q <= 1'b0;
            load_q   <= 1'b0;
            char_q   <= 8'd0;
            vld_q    <= 1'b0;
            eop_q    <= 1'b0;
            pkt_q    <= 16'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            key_q    <= key_d;
            en_cap_q <= en_cap_d;
            first_q  <= first_d;
            alloc_q  <= alloc_d;
            valid_q  <= valid_d;
            sid_q    <= sid_d;
            new_q    <= new_d;
            enable_q <= enable_d;
            load_q   <= load_d;
            char_q   <= char_d;
            vld_q    <= vld_d;
            eop_q    <= eop_d;
            pkt_q    <= pkt_d;
            err_q    <= err_d;
        end
    end

    // Tag contents are qualified by valid_q, so they need no reset.
    always_ff @(posedge clk) begin
        if (tag_we) begin
            tag_q[alloc_q] <= key_q;
        end
    end

    assign load_state    = load_q;
    assign new_stream_id = new_q;
    assign stream_id     = sid_q;
    assign enable        = enable_q;
    assign char_in       = char_q;
    assign char_in_vld   = vld_q;
    assign eop           = eop_q;
    assign pkt_count     = pkt_q;
    assign proto_err     = err_q;

endmodule

// File: tb/tb_dpi_stream_sequencer.sv
// Directed bench for dpi_stream_sequencer: packet vector table plus hand-written
// eviction and protocol-error / mid-packet-reset sequences.
module tb_dpi_stream_sequencer;

    localparam int LOAD_GAP = 2;
    localparam int EOP_GAP  = 2;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_sop;
    logic        in_eop;
    logic [15:0] in_flow_key;
    logic        in_enable;
    logic        load_state;
    logic        new_stream_id;
    logic [5:0]  stream_id;
    logic        enable;
    logic [7:0]  char_in;
    logic        char_in_vld;
    logic        eop;
    logic [15:0] pkt_count;
    logic        proto_err;

    dpi_stream_sequencer #(
        .LOAD_GAP(LOAD_GAP),
        .EOP_GAP (EOP_GAP),
        .KEY_W   (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_sop       (in_sop),
        .in_eop       (in_eop),
        .in_flow_key  (in_flow_key),
        .in_enable    (in_enable),
        .load_state   (load_state),
        .new_stream_id(new_stream_id),
        .stream_id    (stream_id),
        .enable       (enable),
        .char_in      (char_in),
        .char_in_vld  (char_in_vld),
        .eop          (eop),
        .pkt_count    (pkt_count),
        .proto_err    (proto_err)
    );

    typedef struct {
        logic [15:0] key;
        logic        en;
        int          n;
        logic [31:0] bytes;
        int          gap_at;
        int          gap_len;
        int          mid_sop;
        logic        exp_new;
        logic [5:0]  exp_sid;
        logic [15:0] exp_pkt;
        logic        exp_err;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int          load_cnt;
    int          load_cyc;
    logic        load_new;
    logic [5:0]  load_sid;
    logic        load_en;
    int          eop_cnt;
    int          eop_cyc;
    logic        eop_en;
    logic [5:0]  eop_sid;
    int          overlap = 0;
    logic [7:0]  ch_val [$];
    int          ch_cyc [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (load_state) begin
            load_cnt = load_cnt + 1;
            load_cyc = cyc;
            load_new = new_stream_id;
            load_sid = stream_id;
            load_en  = enable;
        end
        if (char_in_vld) begin
            ch_val.push_back(char_in);
            ch_cyc.push_back(cyc);
        end
        if (eop) begin
            eop_cnt = eop_cnt + 1;
            eop_cyc = cyc;
            eop_en  = enable;
            eop_sid = stream_id;
        end
        if (load_state && eop) overlap = overlap + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_mon();
        load_cnt = 0;
        eop_cnt  = 0;
        ch_val.delete();
        ch_cyc.delete();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic drive_beat(input logic [7:0] d, input logic s, input logic e,
                              input logic [15:0] k, input logic en);
        int w;
        w           = 0;
        in_valid    = 1'b1;
        in_data     = d;
        in_sop      = s;
        in_eop      = e;
        in_flow_key = k;
        in_enable   = en;
        #1;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic run_pkt(input vec_t v, input string tag);
        int w;
        int exp_c;
        logic s;
        clear_mon();
        for (int i = 0; i < v.n; i++) begin
            if (v.gap_at > 0 && i == v.gap_at) begin
                in_valid = 1'b0;
                repeat (v.gap_len) @(negedge clk);
            end
            s = (i == 0) || (i == v.mid_sop);
            drive_beat(v.bytes[8*i +: 8], s, (i == v.n - 1), v.key, v.en);
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        w = 0;
        while (eop_cnt == 0 && w < 60) begin
            @(negedge clk);
            w++;
        end
        repeat (2) @(negedge clk);
        chk({tag, ".load_cnt"}, 32'(load_cnt), 32'd1);
        chk({tag, ".new_id"}, 32'(load_new), 32'(v.exp_new));
        chk({tag, ".sid"}, 32'(load_sid), 32'(v.exp_sid));
        chk({tag, ".enable"}, 32'(load_en), 32'(v.en));
        chk({tag, ".n_chars"}, 32'(ch_val.size()), 32'(v.n));
        for (int i = 0; i < v.n; i++) begin
            if (i < ch_val.size()) begin
                exp_c = load_cyc + LOAD_GAP + i + ((v.gap_at > 0 && i >= v.gap_at) ? v.gap_len : 0);
                chk({tag, ".char"}, 32'(ch_val[i]), 32'(v.bytes[8*i +: 8]));
                chk({tag, ".char_cyc"}, 32'(ch_cyc[i]), 32'(exp_c));
            end
        end
        chk({tag, ".eop_cnt"}, 32'(eop_cnt), 32'd1);
        if (ch_cyc.size() > 0) begin
            chk({tag, ".eop_cyc"}, 32'(eop_cyc), 32'(ch_cyc[ch_cyc.size()-1] + EOP_GAP));
        end
        chk({tag, ".eop_enable"}, 32'(eop_en), 32'(v.en));
        chk({tag, ".eop_sid"}, 32'(eop_sid), 32'(v.exp_sid));
        chk({tag, ".pkt_count"}, 32'(pkt_count), 32'(v.exp_pkt));
        chk({tag, ".proto_err"}, 32'(proto_err), 32'(v.exp_err));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, ".load_state"}, 32'(load_state), 32'd0);
        chk({tag, ".new_id"}, 32'(new_stream_id), 32'd0);
        chk({tag, ".sid"}, 32'(stream_id), 32'd0);
        chk({tag, ".enable"}, 32'(enable), 32'd0);
        chk({tag, ".char_in"}, 32'(char_in), 32'd0);
        chk({tag, ".char_vld"}, 32'(char_in_vld), 32'd0);
        chk({tag, ".eop"}, 32'(eop), 32'd0);
        chk({tag, ".pkt_count"}, 32'(pkt_count), 32'd0);
        chk({tag, ".proto_err"}, 32'(proto_err), 32'd0);
    endtask

    vec_t vecs [6];
    vec_t v;

    initial begin
        //          key       en    n  bytes          gap  len sop new   sid   pkt    err
        vecs[0] = '{16'h1234, 1'b1, 4, 32'h44434241, 0,   0,  -1, 1'b1, 6'd0, 16'd1, 1'b0};
        vecs[1] = '{16'h1234, 1'b1, 2, 32'h00005A59, 0,   0,  -1, 1'b0, 6'd0, 16'd2, 1'b0};
        vecs[2] = '{16'hBEEF, 1'b1, 3, 32'h00333231, 0,   0,  -1, 1'b1, 6'd1, 16'd3, 1'b0};
        vecs[3] = '{16'h5555, 1'b0, 1, 32'h0000007F, 0,   0,  -1, 1'b1, 6'd2, 16'd4, 1'b0};
        vecs[4] = '{16'hBEEF, 1'b1, 4, 32'hD4C3B2A1, 2,   3,  -1, 1'b0, 6'd1, 16'd5, 1'b0};
        vecs[5] = '{16'h1234, 1'b1, 3, 32'h000C0B0A, 0,   0,   1, 1'b0, 6'd0, 16'd6, 1'b1};

        in_data     = 8'd0;
        in_flow_key = 16'd0;
        in_enable   = 1'b0;
        clear_mon();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_pkt(vecs[i], $sformatf("vec%0d", i));
        end

        // Fill all 64 slots, wrap on the 65th, then the first key misses again.
        do_reset();
        for (int k = 0; k < 65; k++) begin
            v = '{16'h1000 + 16'(k), 1'b1, 1, 32'(k & 255), 0, 0, -1,
                  1'b1, 6'(k % 64), 16'(k + 1), 1'b0};
            run_pkt(v, $sformatf("fill%0d", k));
        end
        v = '{16'h1000, 1'b1, 1, 32'h000000EE, 0, 0, -1, 1'b1, 6'd1, 16'd66, 1'b0};
        run_pkt(v, "evicted_key");

        // Stray non-sop beat in idle is consumed and dropped.
        clear_mon();
        in_valid = 1'b1;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_data  = 8'h99;
        #1;
        chk("idle_drop.ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_drop.proto_err", 32'(proto_err), 32'd1);
        chk("idle_drop.no_char", 32'(ch_val.size()), 32'd0);
        chk("idle_drop.no_load", 32'(load_cnt), 32'd0);

        // Reset in the middle of a streaming packet.
        drive_beat(8'h11, 1'b1, 1'b0, 16'h2222, 1'b1);
        drive_beat(8'h22, 1'b0, 1'b0, 16'h2222, 1'b1);
        chk("pre_rst.sid", 32'(stream_id), 32'd2);
        chk("pre_rst.enable", 32'(enable), 32'd1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        repeat (10) @(negedge clk);
        chk("mid_rst.no_eop", 32'(eop_cnt), 32'd0);
        v = '{16'h2222, 1'b1, 2, 32'h00004443, 0, 0, -1, 1'b1, 6'd0, 16'd1, 1'b0};
        run_pkt(v, "post_rst");

        chk("load_eop_overlap", 32'(overlap), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
